move_sequencer: RTL and testbench

//  Parametrised successor of the core instruction decoder: sequences fetch/move cycles of the

---
 rtl/move_sequencer_pkg.sv | 17 +
 rtl/move_sequencer_sel_onehot.sv | 13 +
 rtl/move_sequencer.sv | 95 +++++++++
 tb/tb_move_sequencer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/move_sequencer_pkg.sv
// Shared state encodings and default unit select codes for the move sequencer.
package move_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_IMM   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam int unsigned SEL_NULL  = 0;
  localparam int unsigned SEL_IR    = 1;
  localparam int unsigned SEL_IMM   = 11;
  localparam int unsigned SEL_FETCH = 12;

endpackage

// File: rtl/move_sequencer_sel_onehot.sv
// Unit select to one-hot enable vector; all-zero when not enabled.
module sel_onehot #(
  parameter int unsigned SEL_W = 4
) (
  input  logic               en,
  input  logic [SEL_W-1:0]   sel,
  output logic [2**SEL_W-1:0] onehot
);
  localparam int unsigned N = 2**SEL_W;

  assign onehot = en ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;

endmodule

// File: rtl/move_sequencer.sv
// Fetch/move sequencer: decodes captured instruction words into one-hot
// source output-enable and target input-enable buses.
module move_sequencer
  import move_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SEL_W      = 4,
  parameter int unsigned NULL_SEL   = SEL_NULL,
  parameter int unsigned IR_SEL     = SEL_IR,
  parameter int unsigned FETCH_SEL  = SEL_FETCH,
  parameter int unsigned IMM_SEL    = SEL_IMM
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_ins,
  input  logic                  i_ins_valid,
  input  logic                  i_busy,
  input  logic                  i_resume,
  output logic [2**SEL_W-1:0]   o_unit_oen,
  output logic [2**SEL_W-1:0]   o_unit_ien,
  output logic                  o_imm,
  output logic                  o_halted
);

  state_t                state, next;
  logic [DATA_WIDTH-1:0] ins_q;
  logic [SEL_W-1:0]      src, dst, in_src, in_dst;
  logic [SEL_W-1:0]      oen_sel, ien_sel;
  logic                  oen_en, ien_en;

  assign src    = ins_q[2*SEL_W-1:SEL_W];
  assign dst    = ins_q[SEL_W-1:0];
  assign in_src = i_ins[2*SEL_W-1:SEL_W];
  assign in_dst = i_ins[SEL_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      ins_q <= '0;
    end else begin
      state <= next;
      if (state == ST_FETCH && i_ins_valid) ins_q <= i_ins;
    end
  end

  always_comb begin
    next     = state;
    oen_sel  = '0;
    ien_sel  = '0;
    oen_en   = 1'b0;
    ien_en   = 1'b0;
    o_imm    = 1'b0;
    o_halted = 1'b0;
    case (state)
      ST_IDLE: next = ST_FETCH;
      ST_FETCH: begin
        oen_sel = SEL_W'(FETCH_SEL);
        ien_sel = SEL_W'(IR_SEL);
        oen_en  = 1'b1;
        ien_en  = 1'b1;
        if (i_ins_valid) begin
          if (in_src == SEL_W'(NULL_SEL) && in_dst == SEL_W'(NULL_SEL)) next = ST_HALT;
          else if (in_dst == SEL_W'(IR_SEL))                            next = ST_FETCH;
          else if (in_src == SEL_W'(IMM_SEL))                           next = ST_IMM;
          else                                                          next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        oen_sel = src;
        ien_sel = dst;
        oen_en  = 1'b1;
        ien_en  = 1'b1;
        if (!i_busy) next = ST_FETCH;
      end
      // Immediate word streams straight from memory to dst; ins_q keeps the opcode.
      ST_IMM: begin
        oen_sel = SEL_W'(FETCH_SEL);
        ien_sel = dst;
        oen_en  = 1'b1;
        ien_en  = 1'b1;
        o_imm   = 1'b1;
        if (i_ins_valid && !i_busy) next = ST_FETCH;
      end
      ST_HALT: begin
        o_halted = 1'b1;
        if (i_resume) next = ST_FETCH;
      end
      default: next = ST_HALT;
    endcase
  end

  sel_onehot #(.SEL_W(SEL_W)) u_oen (.en(oen_en), .sel(oen_sel), .onehot(o_unit_oen));
  sel_onehot #(.SEL_W(SEL_W)) u_ien (.en(ien_en), .sel(ien_sel), .onehot(o_unit_ien));

endmodule

// File: tb/tb_move_sequencer.sv
// Directed plus randomized bench for move_sequencer against a behavioural model.
module tb_move_sequencer;

  localparam int M_IDLE = 0, M_FETCH = 1, M_EXEC = 2, M_IMM = 3, M_HALT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  i_ins = '0;
  logic        i_ins_valid = 1'b0, i_busy = 1'b0, i_resume = 1'b0;
  logic [15:0] o_unit_oen, o_unit_ien;
  logic        o_imm, o_halted;

  int          vectors = 0, miscompares = 0;
  int          ms = M_IDLE;
  logic [7:0]  mins = '0;

  move_sequencer dut (
    .clk(clk), .rst_n(rst_n), .i_ins(i_ins), .i_ins_valid(i_ins_valid),
    .i_busy(i_busy), .i_resume(i_resume), .o_unit_oen(o_unit_oen),
    .o_unit_ien(o_unit_ien), .o_imm(o_imm), .o_halted(o_halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag);
    logic [15:0] eo, ei;
    logic        eimm, eh;
    eo = '0; ei = '0; eimm = 1'b0; eh = 1'b0;
    case (ms)
      M_FETCH: begin eo = 16'd1 << 12;       ei = 16'd1 << 1; end
      M_EXEC:  begin eo = 16'd1 << mins[7:4]; ei = 16'd1 << mins[3:0]; end
      M_IMM:   begin eo = 16'd1 << 12;       ei = 16'd1 << mins[3:0]; eimm = 1'b1; end
      M_HALT:  eh = 1'b1;
      default: ;
    endcase
    vectors += 4;
    assert (o_unit_oen === eo) else begin
      miscompares++; $error("FAIL %s oen got %h want %h", tag, o_unit_oen, eo);
    end
    assert (o_unit_ien === ei) else begin
      miscompares++; $error("FAIL %s ien got %h want %h", tag, o_unit_ien, ei);
    end
    assert (o_imm === eimm) else begin
      miscompares++; $error("FAIL %s imm got %b want %b", tag, o_imm, eimm);
    end
    assert (o_halted === eh) else begin
      miscompares++; $error("FAIL %s halted got %b want %b", tag, o_halted, eh);
    end
  endtask

  // Model transition from the rules: what happens to the move after this edge.
  task automatic model_step;
    if (!rst_n) begin
      ms = M_IDLE; mins = '0;
    end else begin
      case (ms)
        M_IDLE:  ms = M_FETCH;
        M_FETCH: if (i_ins_valid) begin
          mins = i_ins;
          if (i_ins == 8'h00)              ms = M_HALT;
          else if (i_ins[3:0] == 4'd1)     ms = M_FETCH;
          else if (i_ins[7:4] == 4'd11)    ms = M_IMM;
          else                             ms = M_EXEC;
        end
        M_EXEC:  if (!i_busy) ms = M_FETCH;
        M_IMM:   if (i_ins_valid && !i_busy) ms = M_FETCH;
        M_HALT:  if (i_resume) ms = M_FETCH;
        default: ms = M_HALT;
      endcase
    end
  endtask

  task automatic cyc(input string tag, input logic rst, input logic [7:0] ins,
                     input logic v, input logic b, input logic r);
    rst_n = rst; i_ins = ins; i_ins_valid = v; i_busy = b; i_resume = r;
    @(negedge clk);
    check(tag);
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    @(posedge clk); #1;                          // state defined after first reset edge
    cyc("reset0", 0, 8'h00, 0, 0, 0);
    cyc("reset1", 0, 8'h00, 0, 0, 0);
    cyc("idle",   1, 8'h00, 0, 0, 0);
    // FETCH 34 then EXEC held by two busy cycles
    cyc("fetch34", 1, 8'h34, 1, 0, 0);
    cyc("exec_b1", 1, 8'hFF, 0, 1, 0);
    cyc("exec_b2", 1, 8'hFF, 0, 1, 0);
    cyc("exec_go", 1, 8'hFF, 0, 0, 0);
    // immediate move
    cyc("fetchB5", 1, 8'hB5, 1, 0, 0);
    cyc("imm_wait", 1, 8'h7E, 0, 0, 0);
    cyc("imm_busy", 1, 8'h7E, 1, 1, 0);
    cyc("imm_go",  1, 8'h7E, 1, 0, 0);
    // halt and resume
    cyc("fetch00", 1, 8'h00, 1, 0, 0);
    cyc("halt1",   1, 8'h34, 1, 1, 0);
    cyc("halt2",   1, 8'h00, 0, 0, 0);
    cyc("halt_rs", 1, 8'h00, 0, 0, 1);
    // valid low stall then chained fetch
    for (int i = 0; i < 5; i++) cyc("fetch_stall", 1, 8'h56, 0, 1, 0);
    cyc("fetch21", 1, 8'h21, 1, 0, 0);
    cyc("chained", 1, 8'h77, 1, 0, 0);
    cyc("exec77",  1, 8'h00, 0, 1, 0);
    // reset during busy EXEC
    cyc("rst_exec", 0, 8'h00, 0, 1, 0);
    cyc("post_rst", 1, 8'h00, 0, 0, 0);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [7:0] rins;
      rins = 8'($urandom);
      if ($urandom_range(0, 15) == 0) rins = 8'h00;
      else if ($urandom_range(0, 7) == 0) rins[7:4] = 4'd11;
      cyc("rand", ($urandom_range(0, 63) != 0), rins,
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 3) == 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
